// File: rtl/hls_macc_key_loader_if.sv
// -----------------------------------------------------------------------------
// hls_macc_key_loader_if
//
// Purpose:
//   Bundles the key-load stream, the user start request and the ap_ctrl_hs
//   handshake between the key loader and the obfuscated MACC core.
//
// Signals:
//   key_load_start  pulse: begin or restart a key load
//   key_wdata       key word, least-significant word first
//   key_wvalid      key_wdata valid
//   key_wready      loader accepts a word (transfer = key_wvalid & key_wready)
//   key_loaded      committed key is complete; the core may be started
//   word_count      words accepted in the current load
//   req_start       user request to run the core once
//   core_ap_start   to core ap_start
//   core_ap_ready   from core ap_ready
//   core_ap_done    from core ap_done
//   locking_key     committed key driven to the core
//
// Modports:
//   master - environment side (key source, user, core)
//   slave  - key loader side
// -----------------------------------------------------------------------------
interface hls_macc_key_loader_if #(
    parameter int KEY_W  = 3071,
    parameter int WORD_W = 32
);
    logic              key_load_start;
    logic [WORD_W-1:0] key_wdata;
    logic              key_wvalid;
    logic              key_wready;
    logic              key_loaded;
    logic [6:0]        word_count;
    logic              req_start;
    logic              core_ap_start;
    logic              core_ap_ready;
    logic              core_ap_done;
    logic [KEY_W-1:0]  locking_key;

    modport master (
        output key_load_start,
        output key_wdata,
        output key_wvalid,
        output req_start,
        output core_ap_ready,
        output core_ap_done,
        input  key_wready,
        input  key_loaded,
        input  word_count,
        input  core_ap_start,
        input  locking_key
    );

    modport slave (
        input  key_load_start,
        input  key_wdata,
        input  key_wvalid,
        input  req_start,
        input  core_ap_ready,
        input  core_ap_done,
        output key_wready,
        output key_loaded,
        output word_count,
        output core_ap_start,
        output locking_key
    );
endinterface

// File: rtl/hls_macc_key_loader.sv
// -----------------------------------------------------------------------------
// hls_macc_key_loader
//
// Purpose:
//   Upstream stage of the obfuscated MACC core. Assembles the wide locking key
//   from a word stream into a shadow register and commits it atomically, so
//   the core never observes a partially written key. Gates the core's
//   ap_ctrl_hs start so the core only runs with a complete committed key, and
//   defers any key reload requested while the core is running until it is done.
//
// Ports:
//   ap_clk   clock
//   ap_rst   synchronous active-high reset
//   bus      hls_macc_key_loader_if.slave (key stream, start request, core
//            handshake, committed key)
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module hls_macc_key_loader #(
    parameter int KEY_W  = 3071,
    parameter int WORD_W = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    hls_macc_key_loader_if.slave    bus
);

    localparam int NUM_WORDS = (KEY_W + WORD_W - 1) / WORD_W;
    localparam int SHADOW_W  = NUM_WORDS * WORD_W;
    localparam int CNT_W     = 7;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READY,
        ST_RUN
    } state_e;

    state_e              state_q,         state_d;
    logic [SHADOW_W-1:0] shadow_q,        shadow_d;
    logic [KEY_W-1:0]    locking_key_q,   locking_key_d;
    logic                key_loaded_q,    key_loaded_d;
    logic                key_wready_q,    key_wready_d;
    logic                core_ap_start_q, core_ap_start_d;
    logic [CNT_W-1:0]    word_count_q,    word_count_d;
    logic                reload_pend_q,   reload_pend_d;

    logic                xfer;
    logic                enter_load;

    // key_wready_q is only ever set while in LOAD, so it also qualifies the
    // transfer with the state.
    assign xfer = bus.key_wvalid & key_wready_q;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave it unassigned and infer a latch.
        state_d         = state_q;
        shadow_d        = shadow_q;
        locking_key_d   = locking_key_q;
        key_loaded_d    = key_loaded_q;
        key_wready_d    = key_wready_q;
        core_ap_start_d = core_ap_start_q;
        word_count_d    = word_count_q;
        reload_pend_d   = reload_pend_q;
        enter_load      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                key_loaded_d = 1'b0;
                if (bus.key_load_start) begin
                    enter_load = 1'b1;
                end
            end

            ST_LOAD: begin
                if (bus.key_load_start) begin
                    // Restart: any word offered in this cycle is dropped.
                    enter_load = 1'b1;
                end else if (xfer) begin
                    shadow_d[WORD_W*int'(word_count_q) +: WORD_W] = bus.key_wdata;
                    if (word_count_q == LAST_IDX) begin
                        // Commit includes the word arriving this cycle; the
                        // padding bits of the last word never reach the core.
                        locking_key_d = shadow_d[KEY_W-1:0];
                        key_loaded_d  = 1'b1;
                        key_wready_d  = 1'b0;
                        word_count_d  = '0;
                        state_d       = ST_READY;
                    end else begin
                        word_count_d = word_count_q + 7'd1;
                    end
                end
            end

            ST_READY: begin
                // A reload request wins over a start request.
                if (bus.key_load_start) begin
                    enter_load = 1'b1;
                end else if (bus.req_start) begin
                    core_ap_start_d = 1'b1;
                    state_d         = ST_RUN;
                end
            end

            ST_RUN: begin
                // ap_ctrl_hs: hold ap_start until the core reports ap_ready.
                if (core_ap_start_q && bus.core_ap_ready) begin
                    core_ap_start_d = 1'b0;
                end
                if (bus.key_load_start) begin
                    reload_pend_d = 1'b1;
                end
                if (bus.core_ap_done) begin
                    core_ap_start_d = 1'b0;
                    if (reload_pend_q || bus.key_load_start) begin
                        reload_pend_d = 1'b0;
                        enter_load    = 1'b1;
                    end else begin
                        state_d = ST_READY;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Common entry into LOAD: the committed key stays in place, only the
        // shadow copy and the progress counter start over.
        if (enter_load) begin
            state_d      = ST_LOAD;
            shadow_d     = '0;
            word_count_d = '0;
            key_wready_d = 1'b1;
            key_loaded_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: the shadow and committed key are wide storage but are still
    // cleared on reset so a reset mid-load or mid-run can never expose stale
    // key material to the core.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q         <= ST_IDLE;
            shadow_q        <= '0;
            locking_key_q   <= '0;
            key_loaded_q    <= 1'b0;
            key_wready_q    <= 1'b0;
            core_ap_start_q <= 1'b0;
            word_count_q    <= '0;
            reload_pend_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q         <= state_d;
            shadow_q        <= shadow_d;
            locking_key_q   <= locking_key_d;
            key_loaded_q    <= key_loaded_d;
            key_wready_q    <= key_wready_d;
            core_ap_start_q <= core_ap_start_d;
            word_count_q    <= word_count_d;
            reload_pend_q   <= reload_pend_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.key_wready    = key_wready_q;
    assign bus.key_loaded    = key_loaded_q;
    assign bus.word_count    = word_count_q;
    assign bus.core_ap_start = core_ap_start_q;
    assign bus.locking_key   = locking_key_q;

endmodule

// File: tb/tb_hls_macc_key_loader.sv
// -----------------------------------------------------------------------------
// tb_hls_macc_key_loader
//
// Self-checking bench for hls_macc_key_loader. A behavioural model keeps the
// list of words sent in the current load and the last committed key; the
// expected key is rebuilt from that list by plain concatenation.
// -----------------------------------------------------------------------------
module tb_hls_macc_key_loader;

    localparam int KEY_W     = 3071;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = (KEY_W + WORD_W - 1) / WORD_W;

    logic ap_clk;
    logic ap_rst;

    hls_macc_key_loader_if #(.KEY_W(KEY_W), .WORD_W(WORD_W)) bus ();

    hls_macc_key_loader #(.KEY_W(KEY_W), .WORD_W(WORD_W)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [WORD_W-1:0] model_words [NUM_WORDS];
    logic [KEY_W-1:0]  exp_key;

    function automatic logic [KEY_W-1:0] model_key();
        logic [NUM_WORDS*WORD_W-1:0] full;
        full = '0;
        for (int i = 0; i < NUM_WORDS; i++) full[i*WORD_W +: WORD_W] = model_words[i];
        return full[KEY_W-1:0];
    endfunction

    // Advance one clock; inputs driven after return are seen at the next edge,
    // outputs read after return reflect the edge just taken.
    task automatic cycle();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic pulse_load_start();
        bus.key_load_start = 1'b1;
        cycle();
        bus.key_load_start = 1'b0;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w);
        bit accepted;
        accepted = 1'b0;
        bus.key_wdata  = w;
        bus.key_wvalid = 1'b1;
        for (int t = 0; t < 20 && !accepted; t++) begin
            accepted = bus.key_wready;
            cycle();
        end
        bus.key_wvalid = 1'b0;
        bus.key_wdata  = $urandom;
        checks++;
        if (!accepted) begin
            failures++;
            $display("FAIL word_accept_timeout: key_wready=%0b required=1", bus.key_wready);
        end
    endtask

    // Send words [first, first+count) into the model and the DUT.
    task automatic load_words(input int first, input int count, input bit gaps, input bit pattern);
        logic [WORD_W-1:0] w;
        for (int i = first; i < first + count; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) cycle();
            end
            w = pattern ? (32'hA500_0000 | WORD_W'(i)) : WORD_W'($urandom);
            model_words[i] = w;
            send_word(w);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        ap_rst        = 1'b1;
        bus.req_start = 1'b1;
        cycle();
        cycle();
        checks++;
        if (bus.locking_key !== '0) begin
            failures++; $display("FAIL reset_key: got nonzero required 0");
        end
        checks++;
        if (bus.key_loaded !== 1'b0) begin
            failures++; $display("FAIL reset_loaded: got %0b required 0", bus.key_loaded);
        end
        checks++;
        if (bus.key_wready !== 1'b0) begin
            failures++; $display("FAIL reset_wready: got %0b required 0", bus.key_wready);
        end
        checks++;
        if (bus.core_ap_start !== 1'b0) begin
            failures++; $display("FAIL reset_start: got %0b required 0", bus.core_ap_start);
        end
        checks++;
        if (bus.word_count !== 7'd0) begin
            failures++; $display("FAIL reset_count: got %0d required 0", bus.word_count);
        end
        ap_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (bus.core_ap_start !== 1'b0) begin
                failures++; $display("FAIL idle_req_ignored: core_ap_start=%0b required 0", bus.core_ap_start);
            end
        end
        bus.req_start = 1'b0;
        exp_key = '0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_full_load();
        logic [KEY_W-1:0] k;
        pulse_load_start();
        checks++;
        if (bus.key_wready !== 1'b1) begin
            failures++; $display("FAIL load_wready: got %0b required 1", bus.key_wready);
        end
        load_words(0, 11, 1'b0, 1'b1);
        checks++;
        if (bus.word_count !== 7'd11) begin
            failures++; $display("FAIL load_count: got %0d required 11", bus.word_count);
        end
        load_words(11, NUM_WORDS - 12, 1'b0, 1'b1);
        checks++;
        if (bus.key_loaded !== 1'b0 || bus.locking_key !== exp_key) begin
            failures++; $display("FAIL load_partial_hidden: key_loaded=%0b required 0 (or key changed)", bus.key_loaded);
        end
        load_words(NUM_WORDS - 1, 1, 1'b0, 1'b1);
        exp_key = model_key();
        k = bus.locking_key;
        checks++;
        if (bus.key_loaded !== 1'b1) begin
            failures++; $display("FAIL load_loaded: got %0b required 1", bus.key_loaded);
        end
        checks++;
        if (k !== exp_key) begin
            failures++; $display("FAIL load_key: low word got %h required %h", k[31:0], exp_key[31:0]);
        end
        checks++;
        if (k[31:0] !== 32'hA500_0000) begin
            failures++; $display("FAIL load_key_lsw: got %h required a5000000", k[31:0]);
        end
        checks++;
        if (k[3070:3040] !== 31'h2500_005F) begin
            failures++; $display("FAIL load_key_msw: got %h required 2500005f", k[3070:3040]);
        end
        checks++;
        if (bus.key_wready !== 1'b0 || bus.word_count !== 7'd0) begin
            failures++; $display("FAIL load_done_idle: wready=%0b count=%0d required 0 0", bus.key_wready, bus.word_count);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_start_handshake();
        logic exp_start [4];
        exp_start = '{1'b1, 1'b1, 1'b1, 1'b0};
        bus.req_start = 1'b1;
        cycle();
        bus.req_start = 1'b0;
        // Core model raises ap_ready in the third cycle after the request.
        for (int c = 0; c < 4; c++) begin
            bus.core_ap_ready = (c == 2);
            checks++;
            if (bus.core_ap_start !== exp_start[c]) begin
                failures++; $display("FAIL start_hs_c%0d: core_ap_start=%0b required %0b", c + 1, bus.core_ap_start, exp_start[c]);
            end
            cycle();
        end
        bus.core_ap_ready = 1'b0;
        // A request while running is not queued.
        bus.req_start = 1'b1;
        cycle();
        bus.req_start = 1'b0;
        bus.core_ap_done = 1'b1;
        cycle();
        bus.core_ap_done = 1'b0;
        cycle();
        checks++;
        if (bus.core_ap_start !== 1'b0 || bus.key_loaded !== 1'b1) begin
            failures++; $display("FAIL run_req_ignored: start=%0b loaded=%0b required 0 1", bus.core_ap_start, bus.key_loaded);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_deferred_reload();
        bus.req_start = 1'b1;
        cycle();
        bus.req_start = 1'b0;
        bus.core_ap_ready = 1'b1;
        cycle();
        bus.core_ap_ready = 1'b0;
        pulse_load_start();
        bus.key_wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.key_wdata = $urandom;
            cycle();
            checks++;
            if (bus.key_wready !== 1'b0 || bus.word_count !== 7'd0 || bus.locking_key !== exp_key) begin
                failures++; $display("FAIL defer_blocked: wready=%0b count=%0d required 0 0, key held", bus.key_wready, bus.word_count);
            end
        end
        bus.key_wvalid = 1'b0;
        bus.core_ap_done = 1'b1;
        cycle();
        bus.core_ap_done = 1'b0;
        checks++;
        if (bus.key_loaded !== 1'b0 || bus.key_wready !== 1'b1) begin
            failures++; $display("FAIL defer_enter_load: loaded=%0b wready=%0b required 0 1", bus.key_loaded, bus.key_wready);
        end
        checks++;
        if (bus.locking_key !== exp_key) begin
            failures++; $display("FAIL defer_key_held: low word got %h required %h", bus.locking_key[31:0], exp_key[31:0]);
        end
        load_words(0, NUM_WORDS, 1'b0, 1'b0);
        exp_key = model_key();
        checks++;
        if (bus.locking_key !== exp_key || bus.key_loaded !== 1'b1) begin
            failures++; $display("FAIL defer_new_key: loaded=%0b low word got %h required %h", bus.key_loaded, bus.locking_key[31:0], exp_key[31:0]);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_restart_gaps();
        pulse_load_start();
        load_words(0, 41, 1'b1, 1'b0);
        checks++;
        if (bus.word_count !== 7'd41) begin
            failures++; $display("FAIL restart_pre_count: got %0d required 41", bus.word_count);
        end
        // Restart with a word offered in the same cycle: that word is dropped.
        bus.key_load_start = 1'b1;
        bus.key_wvalid     = 1'b1;
        bus.key_wdata      = $urandom;
        cycle();
        bus.key_load_start = 1'b0;
        bus.key_wvalid     = 1'b0;
        checks++;
        if (bus.word_count !== 7'd0 || bus.key_wready !== 1'b1) begin
            failures++; $display("FAIL restart_count: count=%0d wready=%0b required 0 1", bus.word_count, bus.key_wready);
        end
        load_words(0, 60, 1'b1, 1'b0);
        checks++;
        if (bus.locking_key !== exp_key || bus.key_loaded !== 1'b0 || bus.word_count !== 7'd60) begin
            failures++; $display("FAIL restart_old_held: loaded=%0b count=%0d required 0 60, key held", bus.key_loaded, bus.word_count);
        end
        load_words(60, NUM_WORDS - 60, 1'b1, 1'b0);
        exp_key = model_key();
        checks++;
        if (bus.locking_key !== exp_key || bus.key_loaded !== 1'b1) begin
            failures++; $display("FAIL restart_new_key: loaded=%0b low word got %h required %h", bus.key_loaded, bus.locking_key[31:0], exp_key[31:0]);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_load();
        // In READY a reload request takes precedence over a start request.
        bus.key_load_start = 1'b1;
        bus.req_start      = 1'b1;
        cycle();
        bus.key_load_start = 1'b0;
        bus.req_start      = 1'b0;
        checks++;
        if (bus.core_ap_start !== 1'b0 || bus.key_loaded !== 1'b0 || bus.key_wready !== 1'b1) begin
            failures++; $display("FAIL ready_precedence: start=%0b loaded=%0b wready=%0b required 0 0 1", bus.core_ap_start, bus.key_loaded, bus.key_wready);
        end
        load_words(0, 50, 1'b1, 1'b0);
        checks++;
        if (bus.word_count !== 7'd50) begin
            failures++; $display("FAIL midload_count: got %0d required 50", bus.word_count);
        end
        ap_rst = 1'b1;
        cycle();
        ap_rst = 1'b0;
        exp_key = '0;
        checks++;
        if (bus.locking_key !== exp_key || bus.key_wready !== 1'b0 || bus.word_count !== 7'd0 || bus.key_loaded !== 1'b0) begin
            failures++; $display("FAIL midload_reset: wready=%0b count=%0d loaded=%0b required 0 0 0, key 0", bus.key_wready, bus.word_count, bus.key_loaded);
        end
        bus.req_start = 1'b1;
        cycle();
        bus.req_start = 1'b0;
        cycle();
        checks++;
        if (bus.core_ap_start !== 1'b0 || bus.key_wready !== 1'b0) begin
            failures++; $display("FAIL midload_idle: start=%0b wready=%0b required 0 0", bus.core_ap_start, bus.key_wready);
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        ap_rst             = 1'b1;
        bus.key_load_start = 1'b0;
        bus.key_wdata      = '0;
        bus.key_wvalid     = 1'b0;
        bus.req_start      = 1'b0;
        bus.core_ap_ready  = 1'b0;
        bus.core_ap_done   = 1'b0;
        exp_key            = '0;
        for (int i = 0; i < NUM_WORDS; i++) model_words[i] = '0;

        test_reset();
        test_full_load();
        test_start_handshake();
        test_deferred_reload();
        test_restart_gaps();
        test_reset_mid_load();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
